// File: rtl/pi_loop_filter_pkg.sv
// Shared helpers for the carrier-loop filter blocks: width arithmetic used at elaboration.
package pi_loop_filter_pkg;

  function automatic int unsigned lf_clog2(input int unsigned n);
    return $clog2(n);
  endfunction

  function automatic int unsigned lf_max(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/pi_loop_filter_if.sv
// Sample/control/result bundle between the phase detector side and the loop filter.
interface pi_loop_filter_if #(
    parameter int unsigned DIN_W  = 28,
    parameter int unsigned DOUT_W = 32
);
    logic              ce;
    logic [DIN_W-1:0]  din;
    logic              hold;
    logic              clear;
    logic [DOUT_W-1:0] dout;
    logic              data_valid;
    logic              int_sat;
    logic              out_sat;

    modport master (
        output ce, din, hold, clear,
        input  dout, data_valid, int_sat, out_sat
    );

    modport slave (
        input  ce, din, hold, clear,
        output dout, data_valid, int_sat, out_sat
    );
endinterface

// File: rtl/pi_loop_filter_sat_accum.sv
// Signed add with symmetric saturation to +/-(2^(W-1)-1) and a clip flag.
module sat_accum
    import pi_loop_filter_pkg::*;
#(
    parameter int unsigned W   = 32,
    parameter int unsigned B_W = 32
) (
    input  logic signed [W-1:0]   acc,
    input  logic signed [B_W-1:0] addend,
    output logic signed [W-1:0]   sum,
    output logic                  clip
);
    localparam int unsigned SW = lf_max(W, B_W) + 1;
    localparam logic signed [SW-1:0] MaxV = signed'((SW'(1) << (W - 1)) - SW'(1));
    localparam logic signed [SW-1:0] MinV = -MaxV;

    logic signed [SW-1:0] full;

    assign full = SW'(acc) + SW'(addend);

    always_comb begin
        sum  = full[W-1:0];
        clip = 1'b0;
        if (full > MaxV) begin
            sum  = MaxV[W-1:0];
            clip = 1'b1;
        end else if (full < MinV) begin
            sum  = MinV[W-1:0];
            clip = 1'b1;
        end
    end
endmodule

// File: rtl/pi_loop_filter.sv
// PI loop filter: integrate-and-dump of phase error, then integral + proportional paths
// summed onto START_FREQ and clamped to an NCO frequency word.
module pi_loop_filter
    import pi_loop_filter_pkg::*;
#(
    parameter int unsigned          DIN_W      = 28,
    parameter int unsigned          DOUT_W     = 32,
    parameter int unsigned          INT_W      = 32,
    parameter int unsigned          PERIOD     = 13,
    parameter int unsigned          KI_SHIFT   = 13,
    parameter int unsigned          KP_SHIFT   = 6,
    parameter logic [DOUT_W-1:0]    START_FREQ = 32'h2000_0000,
    parameter logic [DOUT_W-1:0]    FMIN       = 32'h0000_0000,
    parameter logic [DOUT_W-1:0]    FMAX       = 32'hFFFF_FFFF
) (
    input logic               clk,
    input logic               rst_n,
    pi_loop_filter_if.slave   bus
);
    localparam int unsigned CNT_W = lf_clog2(PERIOD);
    localparam int unsigned ACC_W = DIN_W + CNT_W;
    // Wide enough for START_FREQ plus both signed paths without wrapping.
    localparam int unsigned S_W   = lf_max(lf_max(INT_W, ACC_W), DOUT_W) + 2;
    localparam logic signed [S_W-1:0] StartS = S_W'({1'b0, START_FREQ});
    localparam logic signed [S_W-1:0] FminS  = S_W'({1'b0, FMIN});
    localparam logic signed [S_W-1:0] FmaxS  = S_W'({1'b0, FMAX});

    logic signed [ACC_W-1:0]  acc_q, e_q, p_q, acc_sum, ki_term;
    logic [CNT_W-1:0]         cnt_q;
    logic                     dump_v_q, s1_v_q, dv_q, int_sat_q, out_sat_q;
    logic signed [INT_W-1:0]  integ_q, integ_next;
    logic                     integ_clip;
    logic [DOUT_W-1:0]        dout_q, clamped;
    logic signed [S_W-1:0]    s_sum;
    logic                     clamp_hit;

    assign acc_sum = acc_q + ACC_W'(signed'(bus.din));
    assign ki_term = e_q >>> KI_SHIFT;

    sat_accum #(
        .W   (INT_W),
        .B_W (ACC_W)
    ) u_integ (
        .acc    (integ_q),
        .addend (ki_term),
        .sum    (integ_next),
        .clip   (integ_clip)
    );

    assign s_sum = StartS + S_W'(integ_q) + S_W'(p_q);

    always_comb begin
        clamped   = s_sum[DOUT_W-1:0];
        clamp_hit = 1'b0;
        if (s_sum < FminS) begin
            clamped   = FMIN;
            clamp_hit = 1'b1;
        end else if (s_sum > FmaxS) begin
            clamped   = FMAX;
            clamp_hit = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q     <= '0;
            cnt_q     <= '0;
            e_q       <= '0;
            p_q       <= '0;
            dump_v_q  <= 1'b0;
            s1_v_q    <= 1'b0;
            integ_q   <= '0;
            dout_q    <= START_FREQ;
            dv_q      <= 1'b0;
            int_sat_q <= 1'b0;
            out_sat_q <= 1'b0;
        end else if (bus.clear) begin
            // Abort everything in flight; the next period starts from sample zero.
            acc_q     <= '0;
            cnt_q     <= '0;
            dump_v_q  <= 1'b0;
            s1_v_q    <= 1'b0;
            integ_q   <= '0;
            dout_q    <= START_FREQ;
            dv_q      <= 1'b0;
            int_sat_q <= 1'b0;
            out_sat_q <= 1'b0;
        end else begin
            dump_v_q <= 1'b0;
            if (bus.ce) begin
                if (cnt_q == CNT_W'(PERIOD - 1)) begin
                    e_q      <= acc_sum;
                    acc_q    <= '0;
                    cnt_q    <= '0;
                    dump_v_q <= 1'b1;
                end else begin
                    acc_q <= acc_sum;
                    cnt_q <= cnt_q + CNT_W'(1);
                end
            end

            s1_v_q <= dump_v_q;
            if (dump_v_q) begin
                p_q <= e_q >>> KP_SHIFT;
                if (!bus.hold) begin
                    integ_q <= integ_next;
                    if (integ_clip) int_sat_q <= 1'b1;
                end
            end

            dv_q <= s1_v_q;
            if (s1_v_q) begin
                dout_q    <= clamped;
                out_sat_q <= clamp_hit;
            end
        end
    end

    assign bus.dout       = dout_q;
    assign bus.data_valid = dv_q;
    assign bus.int_sat    = int_sat_q;
    assign bus.out_sat    = out_sat_q;
endmodule

// File: tb/tb_pi_loop_filter.sv
// Bench for pi_loop_filter: two instances (default, and INT_W=20 with raised FMIN) share
// stimulus and are compared every cycle against an arithmetic model, plus literal checks.
module tb_pi_loop_filter;
    localparam logic [31:0] START = 32'h2000_0000;
    localparam logic [31:0] FMIN1 = 32'h1FF0_0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ce = 1'b0, hold = 1'b0, clear = 1'b0;
    logic [27:0] din = '0;

    always #5 clk = ~clk;

    pi_loop_filter_if #(.DIN_W(28), .DOUT_W(32)) bus0 ();
    pi_loop_filter_if #(.DIN_W(28), .DOUT_W(32)) bus1 ();

    assign bus0.ce = ce;  assign bus0.din = din;  assign bus0.hold = hold;  assign bus0.clear = clear;
    assign bus1.ce = ce;  assign bus1.din = din;  assign bus1.hold = hold;  assign bus1.clear = clear;

    pi_loop_filter dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));
    pi_loop_filter #(.INT_W(20), .FMIN(FMIN1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

    int n_checks = 0, n_errors = 0, updates = 0, obs_dv = 0, cycles = 0;

    // Model state per instance.
    int     m_intw[2] = '{32, 20};
    longint m_fmin[2] = '{64'd0, 64'h1FF0_0000};
    longint m_fmax    = 64'hFFFF_FFFF;
    longint m_acc[2], m_integ[2], m_e[2], m_oval[2], e_dout[2];
    int     m_cnt[2];
    bit     m_s1[2], m_out[2], m_oosat[2], m_isat[2], e_dv[2], e_osat[2];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic void model_reset(input int k);
        m_acc[k] = 0; m_cnt[k] = 0; m_integ[k] = 0; m_s1[k] = 0; m_out[k] = 0;
        m_isat[k] = 0; e_dout[k] = longint'(START); e_dv[k] = 0; e_osat[k] = 0;
    endfunction

    // One clock of the spec: output of an earlier computed update, then the update computed
    // from the previously dumped error, then the dump of the current sample.
    function automatic void model_step(input int k);
        longint lim, t, p, s;
        if (clear) begin
            model_reset(k);
            return;
        end
        e_dv[k] = 0;
        if (m_out[k]) begin
            e_dout[k] = m_oval[k]; e_osat[k] = m_oosat[k]; e_dv[k] = 1; m_out[k] = 0;
        end
        if (m_s1[k]) begin
            if (!hold) begin
                lim = (longint'(1) <<< (m_intw[k] - 1)) - 1;
                t = m_integ[k] + (m_e[k] >>> 13);
                if (t > lim) begin t = lim; m_isat[k] = 1; end
                else if (t < -lim) begin t = -lim; m_isat[k] = 1; end
                m_integ[k] = t;
            end
            p = m_e[k] >>> 6;
            s = longint'(START) + m_integ[k] + p;
            m_oosat[k] = (s < m_fmin[k]) || (s > m_fmax);
            m_oval[k] = (s < m_fmin[k]) ? m_fmin[k] : (s > m_fmax) ? m_fmax : s;
            m_out[k] = 1; m_s1[k] = 0;
        end
        if (ce) begin
            m_acc[k] += longint'(signed'(din));
            m_cnt[k]++;
            if (m_cnt[k] == 13) begin
                m_e[k] = m_acc[k]; m_s1[k] = 1; m_acc[k] = 0; m_cnt[k] = 0;
            end
        end
    endfunction

    task automatic cmp_dut(input int k, input logic [31:0] d, input logic dv, input logic is,
                           input logic os);
        chk($sformatf("dut%0d dout", k), {32'h0, d}, e_dout[k]);
        chk($sformatf("dut%0d data_valid", k), {63'h0, dv}, {63'h0, e_dv[k]});
        chk($sformatf("dut%0d int_sat", k), {63'h0, is}, {63'h0, m_isat[k]});
        chk($sformatf("dut%0d out_sat", k), {63'h0, os}, {63'h0, e_osat[k]});
    endtask

    task automatic cyc();
        @(posedge clk);
        if (!rst_n) begin model_reset(0); model_reset(1); end
        else begin model_step(0); model_step(1); end
        @(negedge clk);
        cmp_dut(0, bus0.dout, bus0.data_valid, bus0.int_sat, bus0.out_sat);
        cmp_dut(1, bus1.dout, bus1.data_valid, bus1.int_sat, bus1.out_sat);
        if (e_dv[0]) updates++;
        if (bus0.data_valid) obs_dv++;
        cycles++;
    endtask

    // Full period of a constant sample, then wait (bounded) for the resulting pulse.
    task automatic run_period(input logic [27:0] v, output logic [31:0] d0, output logic [31:0] d1);
        int at = -1;
        for (int i = 0; i < 13; i++) begin din = v; ce = 1'b1; cyc(); end
        ce = 1'b0; din = '0;
        d0 = '0; d1 = '0;
        for (int i = 0; i < 5 && at < 0; i++) begin
            cyc();
            if (bus0.data_valid) begin at = i; d0 = bus0.dout; d1 = bus1.dout; end
        end
        chk("dv_latency", 64'(at), 64'd1);
    endtask

    logic [31:0] d0, d1;
    int          mode;

    initial begin
        model_reset(0); model_reset(1);
        repeat (2) cyc();
        chk("reset_dout", {32'h0, bus0.dout}, {32'h0, START});
        chk("reset_dv", {63'h0, bus0.data_valid}, 64'd0);
        rst_n = 1'b1;

        // Idle: no pulses.
        obs_dv = 0;
        repeat (20) cyc();
        chk("idle_no_dv", 64'(obs_dv), 64'd0);

        // 13 x +8192: e=106496, integ=13, p=1664.
        run_period(28'd8192, d0, d1);
        chk("basic_dout0", {32'h0, d0}, 64'h2000_068D);
        chk("basic_dout1", {32'h0, d1}, 64'h2000_068D);

        // Strong negative error: narrow integrator saturates, output clamps at FMIN.
        clear = 1'b1; cyc(); clear = 1'b0;
        repeat (4) run_period(28'h800_0000, d0, d1);
        chk("neg_dout1", {32'h0, d1}, {32'h0, FMIN1});
        chk("neg_out_sat1", {63'h0, bus1.out_sat}, 64'd1);
        chk("neg_int_sat1", {63'h0, bus1.int_sat}, 64'd1);
        chk("neg_int_sat0", {63'h0, bus0.int_sat}, 64'd0);

        // Asynchronous reset with an update in flight.
        for (int i = 0; i < 13; i++) begin din = 28'd8192; ce = 1'b1; cyc(); end
        ce = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("arst_dout1", {32'h0, bus1.dout}, {32'h0, START});
        chk("arst_int_sat1", {63'h0, bus1.int_sat}, 64'd0);
        chk("arst_out_sat1", {63'h0, bus1.out_sat}, 64'd0);
        chk("arst_dv0", {63'h0, bus0.data_valid}, 64'd0);
        model_reset(0); model_reset(1);
        repeat (2) cyc();
        rst_n = 1'b1;
        obs_dv = 0;
        repeat (5) cyc();
        chk("arst_no_dv", 64'(obs_dv), 64'd0);

        // Hold: proportional only, then integration resumes.
        hold = 1'b1;
        for (int n = 0; n < 3; n++) begin
            run_period(28'd8192, d0, d1);
            chk("hold_dout0", {32'h0, d0}, 64'h2000_0680);
        end
        hold = 1'b0;
        run_period(28'd8192, d0, d1);
        chk("unhold_dout0", {32'h0, d0}, 64'h2000_068D);

        // Clear on the dump sample aborts the update.
        for (int i = 0; i < 12; i++) begin din = 28'd8192; ce = 1'b1; cyc(); end
        clear = 1'b1; cyc();
        clear = 1'b0; ce = 1'b0;
        chk("clear_dout0", {32'h0, bus0.dout}, {32'h0, START});
        obs_dv = 0;
        repeat (4) cyc();
        chk("clear_no_dv", 64'(obs_dv), 64'd0);
        run_period(28'd8192, d0, d1);
        chk("after_clear_dout0", {32'h0, d0}, 64'h2000_068D);

        // Random gapped ce, hold toggles, rare clears.
        updates = 0;
        mode = 0;
        while (updates < 2000 && cycles < 60000) begin
            if ($urandom_range(0, 199) == 0) mode = $urandom_range(0, 2);
            ce = ($urandom_range(0, 3) != 0);
            case (mode)
                0: din = 28'($urandom);
                1: din = 28'($signed($urandom_range(0, 8191)) - 4096);
                default: din = 28'h600_0000 + 28'($urandom_range(0, 65535));
            endcase
            if ($urandom_range(0, 49) == 0) hold = ~hold;
            clear = ($urandom_range(0, 2999) == 0);
            cyc();
        end
        clear = 1'b0; ce = 1'b0; hold = 1'b0;
        chk("random_update_budget", {63'h0, updates >= 2000}, 64'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
